// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// Funct3 access-size codes and the byte-enable generator.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCEPT = 2'b01,
    S_RESP   = 2'b10,
    S_DONE   = 2'b11
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte enables for an access of the size encoded in f3[1:0] at byte offset a.
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store-data replication and byte enables on the
// way out, load lane selection and sign/zero extension on the way back.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_f3,
  input  logic [1:0]  st_alo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_alo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0]        ld_shift;
  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  // Store side: replicate the low byte/half across every lane it may land in.
  always_comb begin
    st_be    = be_gen(st_f3, st_alo);
    st_wdata = st_data;
    case (st_f3[1:0])
      2'b00:   st_wdata = {4{st_data[7:0]}};
      2'b01:   st_wdata = {2{st_data[15:0]}};
      default: st_wdata = st_data;
    endcase
  end

  // Load side: shift the addressed lane down to bit 0, then extend by type.
  always_comb begin
    ld_shift = ld_rdata >> {ld_alo, 3'b000};
    ld_byte  = ld_shift[7:0];
    ld_half  = ld_shift[15:0];
    ld_data  = ld_shift;
    case (ld_f3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'd0, ld_shift[7:0]};
      F3_HU:   ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one data-memory transaction per core request
// over a req/ready/rvalid bus, with stall, timeout abort and extended loads.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses complete
// immediately with Err instead of having their low address bits masked.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic        Err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic        we_q;

  logic        f3_legal, trap, timeout;
  logic [1:0]  alo_eff;
  logic        accept_op, fin_err, fin_cap;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  // Decode the request operands: legality, misalignment trap and masked offset.
  always_comb begin
    f3_legal = (Funct3 == F3_B) || (Funct3 == F3_H) || (Funct3 == F3_W) ||
               (!MemWrite && ((Funct3 == F3_BU) || (Funct3 == F3_HU)));
    case (Funct3[1:0])
      2'b01:   alo_eff = {ALUResult[1], 1'b0};
      2'b10:   alo_eff = 2'b00;
      default: alo_eff = ALUResult[1:0];
    endcase
`ifdef MISALIGN_TRAP_EN
    trap = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
           ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
  end

  assign timeout = (cnt_q == TO_LAST);
  assign Stall   = Req & ~Done;

  lsu_lane_align u_align (
    .st_f3    (Funct3),
    .st_alo   (alo_eff),
    .st_data  (WriteData),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_f3    (f3_q),
    .ld_alo   (alo_q),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data)
  );

  // Next-state logic and completion qualifiers.
  always_comb begin
    state_d   = state_q;
    accept_op = 1'b0;
    fin_err   = 1'b0;
    fin_cap   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          if (!f3_legal || trap) begin
            state_d = S_DONE;
            fin_err = 1'b1;
          end else begin
            state_d   = S_ACCEPT;
            accept_op = 1'b1;
          end
        end
      end
      S_ACCEPT: begin
        if (mem_ready) begin
          if (we_q) begin
            state_d = S_DONE;
          end else if (mem_rvalid) begin
            state_d = S_DONE;
            fin_cap = 1'b1;
          end else begin
            state_d = S_RESP;
          end
        end else if (timeout) begin
          state_d = S_DONE;
          fin_err = 1'b1;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          state_d = S_DONE;
          fin_cap = 1'b1;
        end else if (timeout) begin
          state_d = S_DONE;
          fin_err = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Handshake wait counter: restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       cnt_q <= '0;
    else if (state_d != state_q)                      cnt_q <= '0;
    else if (state_q == S_ACCEPT || state_q == S_RESP) cnt_q <= cnt_q + 1'b1;
  end

  // Bus request and operand registers, captured once when an op is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      f3_q      <= '0;
      alo_q     <= '0;
      we_q      <= 1'b0;
    end else if (accept_op) begin
      mem_req   <= 1'b1;
      mem_we    <= MemWrite;
      mem_addr  <= {ALUResult[31:2], 2'b00};
      mem_wdata <= MemWrite ? st_wdata : 32'd0;
      mem_be    <= st_be;
      f3_q      <= Funct3;
      alo_q     <= alo_eff;
      we_q      <= MemWrite;
    end else if (state_q == S_ACCEPT && state_d != S_ACCEPT) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Completion outputs: valid only in the single DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Done     <= 1'b0;
      Err      <= 1'b0;
      ReadData <= '0;
    end else begin
      Done     <= (state_d == S_DONE);
      Err      <= fin_err;
      ReadData <= fin_cap ? ld_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, extended loads, same-cycle
// ready/rvalid, timeout abort, illegal Funct3, misalignment and mid-access reset.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Req, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic        Stall, Done, Err;
  logic [31:0] ReadData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .Stall(Stall), .Done(Done),
    .ReadData(ReadData), .Err(Err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
    Req = 1'b1; MemWrite = we; Funct3 = f3; ALUResult = a; WriteData = d;
    step();
  endtask

  task automatic end_op();
    Req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Req = 0; MemWrite = 0; Funct3 = 0; ALUResult = 0; WriteData = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, Done, Err, Stall} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, Done, Err, Stall});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_be, ReadData} !== '0) begin
      failures++;
      $display("FAIL reset_data addr=%h wdata=%h be=%b rd=%h exp=all zero",
               mem_addr, mem_wdata, mem_be, ReadData);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    start_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, Stall} !== 3'b111) begin
      failures++; $display("FAIL sw_req got req/we/stall=%b exp=111", {mem_req, mem_we, Stall});
    end
    checks++;
    if (mem_be !== 4'b1111 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_bus be=%b addr=%h wdata=%h exp=1111/00000100/deadbeef", mem_be, mem_addr, mem_wdata);
    end
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({Done, Err, Stall, mem_req} !== 4'b1000 || ReadData !== 32'd0) begin
      failures++;
      $display("FAIL sw_done done/err/stall/req=%b rd=%h exp=1000/0", {Done, Err, Stall, mem_req}, ReadData);
    end
    end_op();
  endtask

  task automatic test_store_sub();
    start_op(1'b1, 3'b000, 32'h103, 32'h000000A5);
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h100 || mem_be !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL sb_bus addr=%h be=%b wdata=%h exp=00000100/1000/a5a5a5a5", mem_addr, mem_be, mem_wdata);
    end
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({Done, Err} !== 2'b10) begin
      failures++; $display("FAIL sb_done got=%b exp=10", {Done, Err});
    end
    end_op();
    start_op(1'b1, 3'b001, 32'h102, 32'h1234BEEF);
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_be !== 4'b1100 || mem_wdata !== 32'hBEEFBEEF) begin
      failures++; $display("FAIL sh_bus be=%b wdata=%h exp=1100/beefbeef", mem_be, mem_wdata);
    end
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    end_op();
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
    start_op(1'b0, f3, 32'h102, 32'h0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, Done} !== 2'b00) begin
      failures++; $display("FAIL lb_resp f3=%b req/done=%b exp=00", f3, {mem_req, Done});
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h0080FF00;
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (Done !== 1'b1 || Err !== 1'b0 || ReadData !== exp) begin
      failures++;
      $display("FAIL lb_data f3=%b done=%b err=%b rd=%h exp=1/0/%h", f3, Done, Err, ReadData, exp);
    end
    end_op();
  endtask

  task automatic test_load_half_same_cycle();
    start_op(1'b0, 3'b001, 32'h102, 32'h0);
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80011234;
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (Done !== 1'b1 || Err !== 1'b0 || ReadData !== 32'hFFFF8001) begin
      failures++;
      $display("FAIL lh_same done=%b err=%b rd=%h exp=1/0/ffff8001", Done, Err, ReadData);
    end
    end_op();
  endtask

  task automatic test_timeout();
    int n_req;
    bit seen;
    n_req = 0; seen = 0;
    start_op(1'b0, 3'b010, 32'h200, 32'h0);
    for (int i = 0; i < 3 * TIMEOUT; i++) begin
      @(negedge clk);
      if (Done) begin seen = 1; break; end
      if (mem_req) n_req++;
      step();
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL to_done got=no Done within %0d cycles exp=Done", 3 * TIMEOUT);
    end
    checks++;
    if (n_req !== TIMEOUT) begin
      failures++; $display("FAIL to_len got=%0d req cycles exp=%0d", n_req, TIMEOUT);
    end
    checks++;
    if ({Err, mem_req} !== 2'b10 || ReadData !== 32'd0) begin
      failures++; $display("FAIL to_err err/req=%b rd=%h exp=10/0", {Err, mem_req}, ReadData);
    end
    end_op();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({Done, Err, mem_req} !== 3'b000 || ReadData !== 32'd0) begin
      failures++; $display("FAIL to_late done/err/req=%b rd=%h exp=000/0", {Done, Err, mem_req}, ReadData);
    end
  endtask

  task automatic test_illegal();
    start_op(1'b0, 3'b011, 32'h100, 32'h0);
    @(negedge clk);
    checks++;
    if ({Done, Err, mem_req} !== 3'b110) begin
      failures++; $display("FAIL ill_load done/err/req=%b exp=110", {Done, Err, mem_req});
    end
    end_op();
    start_op(1'b1, 3'b100, 32'h100, 32'h55);
    @(negedge clk);
    checks++;
    if ({Done, Err, mem_req} !== 3'b110) begin
      failures++; $display("FAIL ill_store done/err/req=%b exp=110", {Done, Err, mem_req});
    end
    end_op();
  endtask

  task automatic test_misalign();
    start_op(1'b0, 3'b010, 32'h101, 32'h0);
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    checks++;
    if ({Done, Err, mem_req} !== 3'b110) begin
      failures++; $display("FAIL mis_trap done/err/req=%b exp=110", {Done, Err, mem_req});
    end
`else
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1111) begin
      failures++; $display("FAIL mis_mask req=%b addr=%h be=%b exp=1/00000100/1111", mem_req, mem_addr, mem_be);
    end
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({Done, Err} !== 2'b10 || ReadData !== 32'h11223344) begin
      failures++; $display("FAIL mis_data done/err=%b rd=%h exp=10/11223344", {Done, Err}, ReadData);
    end
`endif
    end_op();
  endtask

  task automatic test_reset_mid();
    start_op(1'b0, 3'b010, 32'h300, 32'h0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    Req = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, Done, Err} !== 3'b000) begin
      failures++; $display("FAIL rst_mid req/done/err=%b exp=000", {mem_req, Done, Err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start_op(1'b0, 3'b010, 32'h300, 32'h0);
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({Done, Err} !== 2'b10 || ReadData !== 32'hCAFEF00D) begin
      failures++; $display("FAIL rst_next done/err=%b rd=%h exp=10/cafef00d", {Done, Err}, ReadData);
    end
    end_op();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_sub();
    test_load_byte(3'b000, 32'hFFFFFF80);
    test_load_byte(3'b100, 32'h00000080);
    test_load_half_same_cycle();
    test_timeout();
    test_illegal();
    test_misalign();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
